// File: rtl/fb_pixel_writer_pkg.sv
// Shared image-size encodings, geometry constants and FSM state type for the
// framebuffer reader and writer, so both sides agree on the buffer packing.
package fb_pixel_writer_pkg;

    localparam int unsigned COORD_W = 10;

    localparam logic [1:0] IMG_HALF    = 2'd0;
    localparam logic [1:0] IMG_FULL    = 2'd1;
    localparam logic [1:0] IMG_QUARTER = 2'd2;

    localparam int unsigned FULL_W    = 320;
    localparam int unsigned FULL_H    = 240;
    localparam int unsigned HALF_W    = 160;
    localparam int unsigned HALF_H    = 120;
    localparam int unsigned QUARTER_W = 80;
    localparam int unsigned QUARTER_H = 60;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned V_DISPLAY = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Encoding 3 is unused and falls back to the half-size image.
    function automatic logic [COORD_W-1:0] img_width(input logic [1:0] sel);
        case (sel)
            IMG_FULL:    return COORD_W'(FULL_W);
            IMG_QUARTER: return COORD_W'(QUARTER_W);
            default:     return COORD_W'(HALF_W);
        endcase
    endfunction

    function automatic logic [COORD_W-1:0] img_height(input logic [1:0] sel);
        case (sel)
            IMG_FULL:    return COORD_W'(FULL_H);
            IMG_QUARTER: return COORD_W'(QUARTER_H);
            default:     return COORD_W'(HALF_H);
        endcase
    endfunction

endpackage

// File: rtl/fb_pixel_writer_raster_counter.sv
// Raster-order x/y position with a running linear address kept equal to
// y*width + x by incrementing alongside the coordinates.
module raster_counter
    import fb_pixel_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] i_width,
    input  logic [COORD_W-1:0] i_height,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_last
);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [ADDR_W-1:0]  r_addr;
    logic               w_x_end;

    assign w_x_end = (r_x == i_width - COORD_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_x_end) begin
                r_x <= '0;
                r_y <= r_y + COORD_W'(1);
            end else begin
                r_x <= r_x + COORD_W'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_addr = r_addr;
    assign o_last = w_x_end && (r_y == i_height - COORD_W'(1));

endmodule

// File: rtl/fb_pixel_writer.sv
// Accepts a valid/ready pixel stream and writes one frame into the dual-port
// framebuffer in raster order, one pixel per cycle with one cycle of latency.
module fb_pixel_writer
    import fb_pixel_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic [1:0]         IMAGE_STATE,
    input  logic [DATA_W-1:0]  PIX_DATA,
    input  logic               PIX_VALID,
    output logic               PIX_READY,
    output logic               W_EN,
    output logic [ADDR_W-1:0]  W_ADDR,
    output logic [DATA_W-1:0]  W_DATA,
    output logic [9:0]         X_OUT,
    output logic [9:0]         Y_OUT,
    output logic               BUSY,
    output logic               DONE
);

    state_t             r_state;
    state_t             w_state_next;
    logic [COORD_W-1:0] r_width;
    logic [COORD_W-1:0] r_height;
    logic               r_w_en;
    logic [ADDR_W-1:0]  r_w_addr;
    logic [DATA_W-1:0]  r_w_data;
    logic               w_accept;
    logic               w_clear;
    logic               w_last;
    logic [ADDR_W-1:0]  w_addr;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A last beat that coincides with ABORT still completes the frame.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_accept = PIX_VALID;
                if (PIX_VALID && w_last) begin
                    w_state_next = ST_DONE;
                end else if (ABORT) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_width  <= COORD_W'(HALF_W);
            r_height <= COORD_W'(HALF_H);
        end else if (w_clear) begin
            r_width  <= img_width(IMAGE_STATE);
            r_height <= img_height(IMAGE_STATE);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_w_en   <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_w_en <= w_accept;
            if (w_accept) begin
                r_w_addr <= w_addr;
                r_w_data <= PIX_DATA;
            end
        end
    end

    raster_counter #(
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk       (CLK),
        .rst_n     (RST_N),
        .i_width   (r_width),
        .i_height  (r_height),
        .i_clear   (w_clear),
        .i_advance (w_accept),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    assign PIX_READY = (r_state == ST_WRITE);
    assign BUSY      = (r_state != ST_IDLE);
    assign DONE      = (r_state == ST_DONE);
    assign W_EN      = r_w_en;
    assign W_ADDR    = r_w_addr;
    assign W_DATA    = r_w_data;
    assign X_OUT     = w_x;
    assign Y_OUT     = w_y;

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Write-side counterpart of the framebuffer read-address generator. Accepts the coprocessor's processed pixel stream over a valid/ready handshake and writes it into the dual-port framebuffer in raster order at the linear address `y*IMG_WIDTH + x`. This is the same packing the VGA side uses to read the buffer. Output image size is selected by `IMAGE_STATE`, using the same encoding as the display path.

## Interface

Parameters
- `ADDR_W`, default 17: framebuffer address width. Must hold 320*240-1 = 76799.
- `DATA_W`, default 8: pixel width (grayscale).

Ports
- `CLK` in 1: system clock.
- `RST_N` in 1: synchronous reset, active-low.
- `START` in 1: begin a frame. Sampled only in IDLE.
- `ABORT` in 1: cancel the current frame. Sampled only in WRITE.
- `IMAGE_STATE` in 2: size select, latched on an accepted `START`.
  - 2: 80x60.
  - 1: 320x240.
  - 0 or 3: 160x120.
- `PIX_DATA` in DATA_W: incoming pixel.
- `PIX_VALID` in 1: `PIX_DATA` is valid.
- `PIX_READY` out 1: block accepts a pixel this cycle.
- `W_EN` out 1: framebuffer write strobe.
- `W_ADDR` out ADDR_W: framebuffer write address.
- `W_DATA` out DATA_W: framebuffer write data.
- `X_OUT` out 10: column of the next pixel to accept.
- `Y_OUT` out 10: row of the next pixel to accept.
- `BUSY` out 1: high in WRITE and DONE.
- `DONE` out 1: single-cycle frame-complete pulse.

## Operation

- FSM states: IDLE, WRITE, DONE. Reset forces IDLE.
- IDLE
  - `PIX_READY`=0.
  - On `START`=1: latch `IMAGE_STATE` into the width/height registers, clear x, y and the address counter, go to WRITE.
- WRITE
  - `PIX_READY`=1, combinationally from state.
  - A beat is accepted when `PIX_VALID && PIX_READY`.
  - Per accepted beat: register `W_DATA`=`PIX_DATA` and `W_ADDR`=current address counter; pulse `W_EN` next cycle; increment the address counter by 1.
  - x increments. When x = width-1, x wraps to 0 and y increments.
  - Last beat is x=width-1 and y=height-1. On the last beat, go to DONE.
- DONE
  - `DONE`=1 for exactly one cycle, `PIX_READY`=0, then go to IDLE.
- Address generation
  - Addresses come from a running counter, not a multiplier.
  - The counter must equal `y*width + x` at all times. Verification checks this invariant.
  - The last address is width*height-1: 4799, 19199 or 76799.
- `ABORT` in WRITE: go to IDLE next cycle. No `DONE`. A beat accepted in the same cycle as `ABORT` is still written. Counters are cleared by the next `START`.
- `START` outside IDLE is ignored. `IMAGE_STATE` changes outside an accepted `START` are ignored.
- `ABORT` outside WRITE is ignored.

## Timing

- Reset values: `PIX_READY`=0, `W_EN`=0, `W_ADDR`=0, `W_DATA`=0, `X_OUT`=0, `Y_OUT`=0, `BUSY`=0, `DONE`=0. Width and height registers reset to 160/120.
- `START` at cycle n → `BUSY` and `PIX_READY` high at n+1.
- Beat accepted at cycle n → `W_EN`=1 with matching address and data at n+1. Write latency is 1 cycle.
- Throughput is 1 pixel/cycle. Gaps in `PIX_VALID` produce gaps in `W_EN` but no address skips.
- Last beat at cycle n → `W_EN` and `DONE` both high at n+1, `PIX_READY` low at n+1, IDLE at n+2.
- The earliest next `START` is accepted at n+2.
- `W_EN` is low in every cycle not following an accepted beat.
- Reset mid-frame: all outputs return to reset values the next cycle. No pending write is issued.

## Structure

- Shared package holds:
  - `IMAGE_STATE` encodings (`IMG_FULL`=1, `IMG_HALF`=0, `IMG_QUARTER`=2).
  - Width/height constants 320/240, 160/120, 80/60.
  - `H_DISPLAY`=640, `V_DISPLAY`=480.
  - FSM state typedef.
- The display-side address generator also imports the size constants, so reader and writer cannot disagree.
- One natural sub-module: `raster_counter`. It holds the x/y/address counters, with inputs width, height, clear and advance, and outputs x, y, addr and last.

## Test plan

- **Quarter frame:** `IMAGE_STATE`=2, `START`, then 4800 continuous beats with `PIX_DATA`=addr[7:0] → exactly 4800 `W_EN` pulses at addresses 0..4799 with data matching. `DONE` pulses once, in the cycle of the write to 4799.
- **Full frame:** `IMAGE_STATE`=1 → beat 320 writes `W_ADDR`=320 while (`X_OUT`,`Y_OUT`)=(0,1) before acceptance. Final address 76799. 76800 writes total.
- **Backpressure:** `IMAGE_STATE`=0 with `PIX_VALID` random at 50% → 19200 writes, strictly consecutive addresses, no `W_EN` in cycles after a non-accepted beat.
- **Encoding 3:** `IMAGE_STATE`=3 → 160x120 behaviour, last address 19199.
- **Ignored controls:** `START` pulsed mid-frame, and `IMAGE_STATE` changed mid-frame → no effect on addresses or size.
- **Abort and reset:** `ABORT` after beat 100 → beat 100 is written at address 100, then no further `W_EN` and no `DONE`. A new `START` restarts at address 0. Separately, `RST_N`=0 mid-frame → all outputs 0 the next cycle.
